// File: rtl/rv32i_dmem_responder_pkg.sv
// rv32i_memPkg: shared types and lane helpers for the RV32I data-memory path.
//   width_e  : request access width (BYTE/HALF/WORD/ILLEGAL)
//   state_e  : responder FSM states (IDLE/SPLIT/RESP)
//   f_size, f_is_cross, f_byte_en, f_byte_en_hi, f_lane_shl, f_lane_shr,
//   f_split_wdata : byte-lane helpers shared by the store and load paths.
package rv32i_memPkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SPLIT = 2'b01,
        RESP  = 2'b10
    } state_e;

    // Access size in bytes; ILLEGAL maps to 4 but is never used as a size.
    function automatic logic [2:0] f_size(input logic [1:0] width);
        case (width)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f_is_cross(input logic [1:0] off, input logic [2:0] n);
        return (({2'b00, off} + {1'b0, n}) > 4'd4);
    endfunction

    // Lanes of the first (or only) word: ((1<<n)-1) << off, truncated to 4 bits.
    function automatic logic [3:0] f_byte_en(input logic [1:0] off, input logic [2:0] n);
        logic [7:0] w_mask;
        w_mask = ((8'd1 << n) - 8'd1) << off;
        return w_mask[3:0];
    endfunction

    // Lanes of the second word of a crossing access: the off+n-4 low bytes.
    function automatic logic [3:0] f_byte_en_hi(input logic [1:0] off, input logic [2:0] n);
        logic [3:0] w_rem;
        logic [7:0] w_mask;
        w_rem  = {2'b00, off} + {1'b0, n} - 4'd4;
        w_mask = (8'd1 << w_rem) - 8'd1;
        return w_mask[3:0];
    endfunction

    function automatic logic [31:0] f_lane_shl(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [31:0] f_lane_shr(input logic [31:0] data, input logic [1:0] off);
        return data >> {off, 3'b000};
    endfunction

    // Store bytes that spill into the next word (offset 0 yields 0).
    function automatic logic [31:0] f_split_wdata(input logic [31:0] data, input logic [1:0] off);
        return data >> (6'd32 - {1'b0, off, 3'b000});
    endfunction

endpackage

// File: rtl/rv32i_dmem_responder_loadalign.sv
// rv32i_loadAlign: combinational load-data alignment.
//   i_word [31:0] : raw RAM word (or stitched word for a split load)
//   i_off  [1:0]  : byte offset of the access within i_word
//   i_n    [2:0]  : access size in bytes (1, 2 or 4)
//   i_sign        : sign-extend from bit 8*n-1 (ignored for words)
//   o_data [31:0] : right-aligned, extended load data
module rv32i_loadAlign
    import rv32i_memPkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_n,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = f_lane_shr(i_word, i_off);

    always_comb begin
        case (i_n)
            3'd1:    o_data = {{24{i_sign & w_shifted[7]}},  w_shifted[7:0]};
            3'd2:    o_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: load/store responder between the RV32I memory stage
// and the data port of a synchronous RAM (read data one cycle after address).
//   clk, reset_n                : clock, synchronous active-low reset
//   req_valid/req_ready         : request handshake
//   req_we/addr/width/sign/wdata: request fields (wdata right-aligned)
//   rsp_valid/rsp_rdata/rsp_err : one-cycle response, no backpressure
//   ram_addr/we/be/wdata        : RAM data-port drive (combinational)
//   ram_rdata                   : RAM read data
// Build option: RV32I_MISALIGN_SPLIT_EN builds the SPLIT state so that
// word-crossing accesses complete as two RAM accesses; without it they
// are answered with rsp_err.
//
// state | meaning
// IDLE  | no transaction outstanding, ready for a request
// SPLIT | second RAM access of a word-crossing request, not ready
// RESP  | rsp_valid high; a new request may be accepted in this cycle
module rv32i_dmem_responder
    import rv32i_memPkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [29:0] ram_addr,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_e      r_state;
    state_e      w_state_nxt;

    logic [1:0]  r_off;
    logic [2:0]  r_n;
    logic        r_sign;
    logic        r_we;
    logic        r_rsp_err;

    logic [1:0]  w_off;
    logic [2:0]  w_n;
    logic        w_illegal;
    logic        w_cross;
    logic        w_err;
    logic        w_accept;
    logic [31:0] w_align_word;
    logic [1:0]  w_align_off;
    logic [31:0] w_load_data;

`ifdef RV32I_MISALIGN_SPLIT_EN
    logic [29:0] r_addr;
    logic        r_split;
    logic [31:0] r_wdata_hi;
    logic [31:0] r_hold;
    logic        w_split;
`endif

    assign w_off     = req_addr[1:0];
    assign w_n       = f_size(req_width);
    assign w_illegal = (req_width == ILLEGAL);
    assign w_cross   = f_is_cross(w_off, w_n);

`ifdef RV32I_MISALIGN_SPLIT_EN
    assign w_err   = w_illegal;
    assign w_split = w_cross & ~w_illegal;
`else
    assign w_err   = w_illegal | w_cross;
`endif

    // Gated by reset_n so nothing is accepted or driven to the RAM while reset is held.
    assign req_ready = reset_n & ((r_state == IDLE) | (r_state == RESP));
    assign w_accept  = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
`ifdef RV32I_MISALIGN_SPLIT_EN
                    if (w_split) w_state_nxt = SPLIT;
                    else
`endif
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
`ifdef RV32I_MISALIGN_SPLIT_EN
            SPLIT:   w_state_nxt = RESP;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = '0;
        ram_be    = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (w_accept && !w_err) begin
            ram_addr  = req_addr[31:2];
            ram_be    = f_byte_en(w_off, w_n);
            ram_wdata = f_lane_shl(req_wdata, w_off);
            ram_we    = req_we;
        end
`ifdef RV32I_MISALIGN_SPLIT_EN
        // reset_n low in SPLIT abandons the transaction before the second write.
        else if (reset_n && (r_state == SPLIT)) begin
            ram_addr  = r_addr + 30'd1;
            ram_be    = f_byte_en_hi(r_off, r_n);
            ram_wdata = r_wdata_hi;
            ram_we    = r_we;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_off      <= '0;
            r_n        <= '0;
            r_sign     <= 1'b0;
            r_we       <= 1'b0;
            r_rsp_err  <= 1'b0;
`ifdef RV32I_MISALIGN_SPLIT_EN
            r_addr     <= '0;
            r_split    <= 1'b0;
            r_wdata_hi <= '0;
            r_hold     <= '0;
`endif
        end else begin
            r_rsp_err <= w_accept & w_err;
            if (w_accept) begin
                r_off      <= w_off;
                r_n        <= w_n;
                r_sign     <= req_sign;
                r_we       <= req_we;
`ifdef RV32I_MISALIGN_SPLIT_EN
                r_addr     <= req_addr[31:2];
                r_split    <= w_split;
                r_wdata_hi <= f_split_wdata(req_wdata, w_off);
`endif
            end
`ifdef RV32I_MISALIGN_SPLIT_EN
            // First-word read data arrives during SPLIT; keep its upper bytes, right-aligned.
            if (r_state == SPLIT) begin
                r_hold <= f_lane_shr(ram_rdata, r_off);
            end
`endif
        end
    end

`ifdef RV32I_MISALIGN_SPLIT_EN
    // A split load is stitched into one right-aligned word and then aligned at offset 0.
    assign w_align_word = r_split ? (r_hold | (ram_rdata << (6'd32 - {1'b0, r_off, 3'b000})))
                                  : ram_rdata;
    assign w_align_off  = r_split ? 2'b00 : r_off;
`else
    assign w_align_word = ram_rdata;
    assign w_align_off  = r_off;
`endif

    rv32i_loadAlign u_load_align (
        .i_word (w_align_word),
        .i_off  (w_align_off),
        .i_n    (r_n),
        .i_sign (r_sign),
        .o_data (w_load_data)
    );

    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = (rsp_valid && !r_we && !r_rsp_err) ? w_load_data : '0;

endmodule

// File: doc/rv32i_dmem_responder.md
# rv32i_dmem_responder

Data-memory responder for the RV32I core. It accepts load/store requests from the execute/memory stage over a valid/ready handshake and drives the synchronous dual-port RAM's data port (word address, byte enables, lane-shifted write data). It returns sign- or zero-extended load data with a single-cycle response pulse. Accesses that cross a word boundary are split into two RAM accesses by a small state machine when the split feature is compiled in.

## Interface
- No parameters. RAM depth is set by the RAM; the address width is fixed at 32 bits.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `reset_n` in 1: synchronous reset, active low.
- `req_valid` in 1: request present.
- `req_ready` out 1: the responder can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address, normally `alu_out`.
- `req_width` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_sign` in 1: 1 = sign-extend load data.
- `req_wdata` in 32: store data, right-aligned (`rs2_data`).
- `rsp_valid` out 1: one-cycle response pulse. There is no backpressure on the response.
- `rsp_rdata` out 32: extended load data. Reads 0 for stores and errors.
- `rsp_err` out 1: error flag, qualified by `rsp_valid`.
- `ram_addr` out 30: word address to the RAM data port.
- `ram_we` out 1: RAM write strobe.
- `ram_be` out 4: RAM byte-lane enables.
- `ram_wdata` out 32: lane-shifted write data.
- `ram_rdata` in 32: RAM read data, returned one cycle after the address.

## Operation
- **Handshake.** A request transfers on `req_valid && req_ready`. `req_ready` is 1 in IDLE and in the final cycle of a transaction (the cycle `rsp_valid` is high), so aligned traffic can issue back-to-back.
- **Definitions.**
  - Offset: `off = req_addr[1:0]`.
  - Size in bytes: `n` = 1, 2 or 4.
  - An access is crossing when `off + n > 4`: a half at offset 3, or a word at offset 1–3.
  - A non-crossing access is served in one word, even when it is not naturally aligned.
- **RAM drive on acceptance.** The first access is driven combinationally on the accept cycle:
  - `ram_addr = req_addr[31:2]`.
  - `ram_be = ((1<<n)-1) << off`, truncated to 4 bits.
  - `ram_wdata = req_wdata << 8*off`.
  - `ram_we = req_we`.
- **Latched state.** The responder latches `off`, `n`, `req_sign`, `req_we`, and the split store data for later cycles.
- **Load extraction.**
  - Shift `ram_rdata` right by `8*off`.
  - Mask to `n` bytes.
  - Extend from bit `8n-1` when the latched sign bit is set.
  - A word load ignores sign.
- **States.**
  - IDLE → RESP on accepting a non-crossing request, an error, or (with the feature off) a crossing request.
  - IDLE → SPLIT on accepting a crossing request with the feature on.
  - SPLIT → RESP unconditionally.
  - RESP → IDLE, or RESP → RESP/SPLIT if a new request is accepted in the same cycle.
- **SPLIT cycle.**
  - Drives `ram_addr = first+1`, `ram_be = (1<<(off+n-4))-1`.
  - Write data for the second access is `req_wdata >> 8*(4-off)`.
  - On a load, the low part from the first read is captured into a holding register.
  - `req_ready = 0`.
- **RESP cycle.**
  - `rsp_valid = 1`.
  - For a split load, the low `4-off` bytes come from the holding register and the high bytes from `ram_rdata`.
- **Errors.**
  - Width 11, and crossing requests with the feature off, produce `ram_we = 0`, `ram_be = 0`, `rsp_err = 1` and `rsp_rdata = 0`.
  - No RAM write ever occurs for an errored request.
- **Reset values.**
  - State IDLE.
  - `req_ready = 1` after reset is released. It is 0 while `reset_n` is low.
  - `rsp_valid`, `rsp_err` and `rsp_rdata` are 0.
  - `ram_we` and `ram_be` are 0.
  - `ram_addr` and `ram_wdata` are 0.
- **Reset mid-operation.** Reset asserted in SPLIT abandons the transaction: the second write is not performed and no response is issued.

## Timing
- Aligned load or store: accepted in cycle 0, `rsp_valid` in cycle 1. Throughput is 1 request per cycle.
- Crossing access (feature on): accepted in cycle 0, second access in cycle 1, `rsp_valid` in cycle 2. The next request can be accepted in cycle 2.
- Errored request: `rsp_valid`/`rsp_err` in cycle 1.
- Store visibility: a store's write lands on the cycle-0 edge (first part) and the cycle-1 edge (split part). A load accepted in the response cycle of a store reads the new data.
- Output registration: `rsp_rdata` and `ram_*` are combinational from latched state plus `ram_rdata` or the request. `rsp_valid` and `rsp_err` are registered.

## Configuration
- `RV32I_MISALIGN_SPLIT_EN`:
  - Defined: the SPLIT state and holding register are built, and crossing accesses complete in two RAM accesses.
  - Undefined: no SPLIT state; crossing accesses return `rsp_err = 1` in cycle 1 with no RAM write.

## Structure
- Package `rv32i_memPkg`:
  - width enum (BYTE/HALF/WORD/ILLEGAL);
  - state enum (IDLE/SPLIT/RESP);
  - byte-enable and lane-shift functions, shared with the store path.
- One sub-module, `rv32i_loadAlign`: combinational shift, mask and extend from `{word, off, n, sign}`. It is reused for both split and non-split loads.

## Test plan
- Store byte 0x80 at 0x50, then signed byte load at 0x50 → `ram_be` 0001, rsp 0xFFFFFF80. Same load unsigned → 0x00000080.
- Store word 0x12345678 at 0x60, then signed half load at 0x62 → 0x00001234; signed byte load at 0x63 → 0x00000012.
- Feature on: store word 0xAABBCCDD at 0x63 → word 0x18 be 1000 data 0xDD000000, then word 0x19 be 0111 data 0x00AABBCC. Load word 0x63 → 0xAABBCCDD with `rsp_valid` in cycle 2.
- Feature off: the same store → `rsp_err = 1` in cycle 1, RAM unchanged.
- Width 11 load at 0x40 → `rsp_err = 1`, `rsp_rdata = 0`, `ram_we = 0`.
- Back-to-back aligned store then load to 0x70 in consecutive cycles → new data returned, one response per cycle. Crossing store with `reset_n` low in the SPLIT cycle → word 0x19 not written, no `rsp_valid`.
